// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master sequencing 16-bit addressed byte read/write frames
module spi_master_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;

    logic        handshake;
    logic        div_tc;
    logic [15:0] frame;

    assign handshake = req_valid && req_ready_q;
    assign div_tc    = (cnt_q == DIV_LAST);
    assign frame     = {req_addr, req_rw, (req_rw ? 8'h00 : req_wdata)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // bit_cnt_q counts sclk rises already issued; the first rise happens on SETUP exit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d   = SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shreg_d   = frame;
                    rx_d      = '0;
                    rw_d      = req_rw;
                end
            end
            SETUP: begin
                if (div_tc) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    bit_cnt_d = 5'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (div_tc) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bit_cnt_q == 5'd16) begin
                        // one extra low half-period after the last fall before HOLD
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q[3]) begin
                            rx_d = {rx_q[6:0], miso};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (div_tc) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_d        = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_q == HOLD) && (state_d == GAP);
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_valid_d) begin
            rsp_rdata_d = rw_q ? rx_q : 8'h00;
        end
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        if (state_q == IDLE && handshake) begin
            mosi_d = frame[15];
        end else if (state_q == SETUP && div_tc) begin
            sclk_d = 1'b1;
        end else if (state_q == SHIFT && div_tc && state_d == SHIFT) begin
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                mosi_d = shreg_q[14];
            end
        end
        if (!(state_d == SETUP || state_d == SHIFT)) begin
            sclk_d = 1'b0;
            mosi_d = 1'b0;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign mosi      = mosi_q;
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master sequencer that drives the SPI memory slave (addressed-byte read/write) from a parallel request/response interface.
- Accepts one request at a time and serialises it into a 16-bit frame on sclk/cs/mosi: 7-bit address, rw bit, 8 data bits.
- For reads, captures the slave's miso data byte and returns it on the response port.
- Sits between a host/bus agent and the chip-select/serial pins of the memory slave.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 2.
- GAP_CYCLES, 8, minimum clk cycles cs stays high between frames; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; transfer occurs when req_valid && req_ready.
- req_rw  input  1  1 = read, 0 = write.
- req_addr  input  7  target address.
- req_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse at frame end.
- rsp_rdata  output  8  read byte, valid with rsp_valid; 0x00 for writes.
- busy  output  1  high from acceptance through end of GAP.
- sclk  output  1  serial clock, idle low (mode 0).
- cs  output  1  chip select, active low, idle high.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in from slave.

Behaviour:
- Reset: async clear of all state.
  - Outputs: cs=1, sclk=0, mosi=0, rsp_valid=0, rsp_rdata=0x00, busy=0, req_ready=1.
  - Reset mid-frame aborts the frame. No rsp_valid is issued for it. cs returns high immediately.
- All outputs are registered.
- Acceptance:
  - On the handshake cycle, latch frame = {addr[6:0], rw, wdata[7:0]} into a 16-bit shift register. For reads, the data byte field is 0.
  - Enter SETUP.
  - req_valid while not ready is ignored. The request is not queued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: cs=1, sclk=0, req_ready=1.
- SETUP:
  - First cycle after acceptance: cs=0, mosi=frame[15], sclk=0.
  - After CLK_DIV cycles, enter SHIFT.
- SHIFT:
  - Divider counts CLK_DIV cycles per half-period; sclk toggles at each terminal count.
  - On each rising sclk transition, bit counter (0..15) increments.
  - During bits 8..15 (data phase), sample miso into rdata shift register, MSB first. Sampling uses the miso value present in the cycle sclk goes 0->1.
  - On each falling transition, shift so mosi presents the next frame bit. Slave samples on sclk rise; mosi is stable for a full half-period before each rise.
  - After the 16th rise and its subsequent fall, enter HOLD with sclk=0 and mosi=0.
  - Exactly 16 sclk pulses per frame.
- HOLD: cs held low for CLK_DIV cycles, then enter GAP.
- GAP entry cycle:
  - cs=1.
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata = captured byte for reads, 0x00 for writes. rsp_rdata holds its value until the next rsp_valid.
- GAP: cs high for GAP_CYCLES cycles, then IDLE.
- Latency, counting the acceptance cycle as 0:
  - cs falls at cycle 1.
  - First sclk rise at cycle 1+CLK_DIV.
  - rsp_valid at cycle 1+34*CLK_DIV.
  - req_ready returns at cycle 1+34*CLK_DIV+GAP_CYCLES.
  - With defaults: rsp_valid at 137, ready at 145.
- busy = (state != IDLE).
- No backpressure on the response; the consumer must take rsp_valid when pulsed.

Test Plan:
- Write 0xFF to addr 0x00 (defaults), bench slave model captures frame -> slave sees 16 rising-edge bits 0000000_0_11111111; cs low for cycles 1..136; rsp_valid at cycle 137 with rsp_rdata=0x00.
- Read addr 0x00 with slave model driving 0xA5 on miso during data phase -> mosi frame 0000000_1_00000000; rsp_valid at 137 with rsp_rdata=0xA5.
- Back-to-back: req_valid held high with two requests (write 0x3C to 0x12, read 0x12) -> second accepted exactly at cycle 145; cs high for >= 8 cycles between frames; read returns 0x3C.
- Request while busy: pulse req_valid at cycle 50 of a frame -> ignored, req_ready=0, no extra frame, no extra rsp_valid.
- Reset mid-frame: assert rst_n=0 after 5 sclk pulses -> cs=1, sclk=0, mosi=0 asynchronously; no rsp_valid; after release, a new write completes normally.
- CLK_DIV=2, GAP_CYCLES=1: read addr 0x7F with slave returning 0x81 -> sclk period 4 clk; rsp_valid at cycle 69 with rsp_rdata=0x81; req_ready back at cycle 70.
